ram_access_ctrl: RTL
====================

Name: ram_access_ctrl

Overview:
- Upstream controller for the 4x1-bit gated-clock RAM stage. It takes a serial write stream (valid/ready) and drives the RAM's addr, d and clock-strobe inputs.
- On request it scans all addresses, captures the RAM read bit and presents the whole contents as one parallel word.
- It guarantees addr and d are stable around every strobe, because the RAM gates its clock with addr.

Parameters:
- ADDR_W, 2, RAM address width; DEPTH = 2**ADDR_W words of 1 bit.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- wr_valid  in  1  a write bit is offered.
- wr_bit  in  1  data bit to write.
- wr_ready  out  1  controller can accept a write this cycle.
- rd_start  in  1  request a full-memory readback; sampled only in IDLE.
- ptr_clr  in  1  reset the write pointer to 0; honoured only in IDLE.
- ram_addr  out  ADDR_W  address to the RAM.
- ram_d  out  1  data to the RAM.
- ram_we  out  1  registered write strobe; drives the RAM clock input.
- ram_q  in  1  RAM read bit for ram_addr (combinational in the RAM).
- rd_word  out  DEPTH  captured contents; bit i = word i.
- rd_valid  out  1  one-cycle pulse when rd_word is updated.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, wr_ptr=0, ram_addr=0, ram_d=0, ram_we=0, rd_word=0, rd_valid=0, busy=0.
  - wr_ready=1 once rst_n is released.
  - Reset mid-write forces ram_we low immediately, with no partial strobe extension.
- wr_ready = (state==IDLE). It is derived from state only, with no combinational path from inputs.
- States: IDLE, W_SETUP, W_STROBE, W_HOLD, R_ADDR, R_SAMPLE, R_DONE.
- IDLE priority (highest first): ptr_clr, then write handshake, then rd_start.
  - ptr_clr=1: wr_ptr<=0, stay in IDLE. A simultaneous write or rd_start is not accepted (wr_ready still 1 but the handshake is ignored; the bench must not rely on it).
  - wr_valid&wr_ready: ram_addr<=wr_ptr, ram_d<=wr_bit, go to W_SETUP.
  - rd_start (no write): ram_addr<=0, scan index<=0, go to R_ADDR.
- Write sequence, 3 cycles after acceptance, back in IDLE on the 4th edge:
  - W_SETUP: ram_we=0, addr/d stable. ram_we<=1 on exit.
  - W_STROBE: ram_we=1 for exactly one cycle (RAM captures on this rising edge). ram_we<=0 on exit.
  - W_HOLD: ram_we=0, addr/d unchanged. wr_ptr<=wr_ptr+1, wrapping DEPTH-1 -> 0.
- Read sequence, 2 cycles per address:
  - R_ADDR: ram_addr=index, ram_we=0.
  - R_SAMPLE: rd_word[index]<=ram_q.
    - index<DEPTH-1: index+1 -> R_ADDR.
    - index==DEPTH-1: go to R_DONE.
  - R_DONE: rd_valid=1 for one cycle -> IDLE, ram_addr<=wr_ptr.
- Total read latency from rd_start acceptance to rd_valid is 2*DEPTH+1 cycles (9 for DEPTH=4).
- rd_word holds its value between scans.
- ram_addr changes only when ram_we=0 and ram_we is low on the previous cycle, so there is no glitch on RAM-side gated clocks.
- wr_ptr is unaffected by reads.

Optional Feature:
- RAM_ACCESS_CTRL_VERIFY_EN defined:
  - Adds state W_CHECK after W_HOLD, in which ram_q is compared to ram_d.
  - On mismatch, sets a sticky output verify_err (1 bit, reset 0, cleared only by rst_n).
  - Write takes 4 cycles.
- Macro undefined: no W_CHECK, no verify_err port, write takes 3 cycles.

Decomposition:
- Package ram_access_pkg:
  - state enum type;
  - localparam function for DEPTH from ADDR_W;
  - write-sequence length constants (3 or 4 cycles).
- No sub-module is needed; the FSM, pointer and capture register stay in one module.

Test Plan:
- Reset then idle -> all outputs 0 except wr_ready=1; busy=0.
- Write 1,0,1,1 back-to-back with wr_valid held -> accepts every 4th cycle; ram_we pulses at addr 0,1,2,3 with d 1,0,1,1; wr_ptr wraps to 0.
- After that, pulse rd_start -> rd_valid 9 cycles later, rd_word=4'b1101; ram_we stays 0 throughout.
- wr_valid and rd_start asserted together in IDLE -> write wins; rd_start is ignored unless still high when IDLE returns.
- Write at addr 2, then assert rst_n=0 during W_STROBE -> ram_we drops asynchronously; wr_ptr=0, rd_word=0 after release.
- With VERIFY_EN and RAM model forcing ram_q=0, write 1 -> verify_err=1 and stays 1 through later good writes.

Source files
------------

// File: rtl/ram_access_ctrl_pkg.sv
// rtl/ram_access_ctrl_pkg.sv - shared types and constants for ram_access_ctrl
// RAM_ACCESS_CTRL_VERIFY_EN adds the W_CHECK read-back state and lengthens writes to 4 cycles.
package ram_access_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_W_SETUP,
    ST_W_STROBE,
    ST_W_HOLD,
    ST_R_ADDR,
    ST_R_SAMPLE,
    ST_R_DONE
`ifdef RAM_ACCESS_CTRL_VERIFY_EN
    , ST_W_CHECK
`endif
  } state_t;

  function automatic int depth_f(input int addr_w);
    return 1 << addr_w;
  endfunction

  // Cycles from write acceptance until IDLE is re-entered.
`ifdef RAM_ACCESS_CTRL_VERIFY_EN
  localparam int WRITE_CYCLES = 4;
`else
  localparam int WRITE_CYCLES = 3;
`endif

endpackage

// File: rtl/ram_access_ctrl_if.sv
// rtl/ram_access_ctrl_if.sv - write stream, readback and RAM-side signals of ram_access_ctrl
// RAM_ACCESS_CTRL_VERIFY_EN adds the sticky verify_err flag.
interface ram_access_ctrl_if #(
  parameter int ADDR_W = 2
);
  import ram_access_pkg::*;

  localparam int DEPTH = depth_f(ADDR_W);

  logic              wr_valid;
  logic              wr_bit;
  logic              wr_ready;
  logic              rd_start;
  logic              ptr_clr;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_d;
  logic              ram_we;
  logic              ram_q;
  logic [DEPTH-1:0]  rd_word;
  logic              rd_valid;
  logic              busy;
`ifdef RAM_ACCESS_CTRL_VERIFY_EN
  logic              verify_err;
`endif

  modport master (
    input  wr_valid, wr_bit, rd_start, ptr_clr, ram_q,
`ifdef RAM_ACCESS_CTRL_VERIFY_EN
    output verify_err,
`endif
    output wr_ready, ram_addr, ram_d, ram_we, rd_word, rd_valid, busy
  );

  modport slave (
    output wr_valid, wr_bit, rd_start, ptr_clr, ram_q,
`ifdef RAM_ACCESS_CTRL_VERIFY_EN
    input  verify_err,
`endif
    input  wr_ready, ram_addr, ram_d, ram_we, rd_word, rd_valid, busy
  );

endinterface

// File: rtl/ram_access_ctrl.sv
// rtl/ram_access_ctrl.sv - serial writer and full-memory reader for a gated-clock 1-bit RAM
// RAM_ACCESS_CTRL_VERIFY_EN enables post-write read-back checking into verify_err.
module ram_access_ctrl
  import ram_access_pkg::*;
#(
  parameter int ADDR_W = 2
) (
  input logic               clk,
  input logic               rst_n,
  ram_access_ctrl_if.master bus_io
);

  localparam int DEPTH = depth_f(ADDR_W);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              d_q, d_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DEPTH-1:0]  rd_word_q, rd_word_d;
  logic              rd_valid_q, rd_valid_d;
`ifdef RAM_ACCESS_CTRL_VERIFY_EN
  logic              verify_err_q, verify_err_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      addr_q     <= '0;
      d_q        <= 1'b0;
      we_q       <= 1'b0;
      idx_q      <= '0;
      rd_word_q  <= '0;
      rd_valid_q <= 1'b0;
`ifdef RAM_ACCESS_CTRL_VERIFY_EN
      verify_err_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      addr_q     <= addr_d;
      d_q        <= d_d;
      we_q       <= we_d;
      idx_q      <= idx_d;
      rd_word_q  <= rd_word_d;
      rd_valid_q <= rd_valid_d;
`ifdef RAM_ACCESS_CTRL_VERIFY_EN
      verify_err_q <= verify_err_d;
`endif
    end
  end

  // Address only moves in IDLE exit, R_SAMPLE and R_DONE, all of which follow a cycle with ram_we low.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    addr_d     = addr_q;
    d_d        = d_q;
    we_d       = 1'b0;
    idx_d      = idx_q;
    rd_word_d  = rd_word_q;
    rd_valid_d = 1'b0;
`ifdef RAM_ACCESS_CTRL_VERIFY_EN
    verify_err_d = verify_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus_io.ptr_clr) begin
          wr_ptr_d = '0;
        end else if (bus_io.wr_valid) begin
          addr_d  = wr_ptr_q;
          d_d     = bus_io.wr_bit;
          state_d = ST_W_SETUP;
        end else if (bus_io.rd_start) begin
          addr_d  = '0;
          idx_d   = '0;
          state_d = ST_R_ADDR;
        end
      end
      ST_W_SETUP: begin
        we_d    = 1'b1;
        state_d = ST_W_STROBE;
      end
      ST_W_STROBE: begin
        state_d = ST_W_HOLD;
      end
      ST_W_HOLD: begin
        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
`ifdef RAM_ACCESS_CTRL_VERIFY_EN
        state_d  = ST_W_CHECK;
`else
        state_d  = ST_IDLE;
`endif
      end
`ifdef RAM_ACCESS_CTRL_VERIFY_EN
      ST_W_CHECK: begin
        if (bus_io.ram_q != d_q) verify_err_d = 1'b1;
        state_d = ST_IDLE;
      end
`endif
      ST_R_ADDR: begin
        state_d = ST_R_SAMPLE;
      end
      ST_R_SAMPLE: begin
        rd_word_d[idx_q] = bus_io.ram_q;
        if (idx_q == LAST_IDX) begin
          state_d = ST_R_DONE;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          addr_d  = idx_q + ADDR_W'(1);
          state_d = ST_R_ADDR;
        end
      end
      ST_R_DONE: begin
        rd_valid_d = 1'b1;
        addr_d     = wr_ptr_q;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus_io.wr_ready = (state_q == ST_IDLE);
  assign bus_io.busy     = (state_q != ST_IDLE);
  assign bus_io.ram_addr = addr_q;
  assign bus_io.ram_d    = d_q;
  assign bus_io.ram_we   = we_q;
  assign bus_io.rd_word  = rd_word_q;
  assign bus_io.rd_valid = rd_valid_q;
`ifdef RAM_ACCESS_CTRL_VERIFY_EN
  assign bus_io.verify_err = verify_err_q;
`endif

endmodule
